ap_txn_profiler: RTL and testbench



---
 rtl/ap_prof_pkg.sv | 20 ++
 rtl/prof_rec_fifo.sv | 55 +++++
 rtl/ap_txn_profiler.sv | 147 ++++++++++++++
 tb/tb_ap_txn_profiler.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ap_prof_pkg.sv
// Shared types for the ap_ctrl_hs transaction profiler: FSM states and the
// record layout carried through the record FIFO.
package ap_prof_pkg;

    localparam int unsigned PROF_TS_W  = 32;
    localparam int unsigned PROF_SEQ_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } prof_state_e;

    typedef struct packed {
        logic [PROF_SEQ_W-1:0] seq;
        logic [PROF_TS_W-1:0]  start_ts;
        logic [PROF_TS_W-1:0]  lat;
        logic [PROF_TS_W-1:0]  ii;
    } prof_rec_t;

endpackage

// File: rtl/prof_rec_fifo.sv
// First-word-fall-through record FIFO with extra-bit pointers; a push into a
// full FIFO is accepted when a pop happens in the same cycle.
module prof_rec_fifo
    import ap_prof_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  prof_rec_t push_data,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output prof_rec_t head
);

    localparam int unsigned AW = $clog2(DEPTH);

    prof_rec_t     mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        head     = mem_q[rd_ptr_q[AW-1:0]];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/ap_txn_profiler.sv
// Profiles ap_ctrl_hs transactions: timestamps start and done, derives latency
// and start-to-start interval, and queues one record per completed transaction.
module ap_txn_profiler
    import ap_prof_pkg::*;
#(
    parameter int unsigned TS_W  = 32,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned SEQ_W = 16
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             enable,
    input  logic             mon_ap_start,
    input  logic             mon_ap_ready,
    input  logic             mon_ap_done,
    input  logic             mon_ap_continue,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [SEQ_W-1:0] rec_seq,
    output logic [TS_W-1:0]  rec_start_ts,
    output logic [TS_W-1:0]  rec_lat,
    output logic [TS_W-1:0]  rec_ii,
    output logic [SEQ_W-1:0] overflow_cnt,
    output logic             busy
);

    prof_state_e      state_q, state_d;
    logic [TS_W-1:0]  ts_q, ts_d;
    logic [TS_W-1:0]  start_ts_q, start_ts_d;
    logic [TS_W-1:0]  ii_q, ii_d;
    logic [TS_W-1:0]  last_start_q, last_start_d;
    logic             ready_seen_q, ready_seen_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic [SEQ_W-1:0] ovf_q, ovf_d;

    logic             done_hs;
    logic             done_evt;
    logic [TS_W-1:0]  start_ii;
    logic [TS_W-1:0]  evt_start_ts, evt_lat, evt_ii;
    prof_rec_t        push_rec;
    prof_rec_t        head;
    logic             fifo_full, fifo_empty, fifo_pop;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        ts_d         = ts_q + TS_W'(1);
        start_ts_d   = start_ts_q;
        ii_d         = ii_q;
        last_start_d = last_start_q;
        ready_seen_d = ready_seen_q | mon_ap_ready;
        done_evt     = 1'b0;
        evt_start_ts = '0;
        evt_lat      = '0;
        evt_ii       = '0;
        done_hs      = mon_ap_done && mon_ap_continue;
        start_ii     = ready_seen_q ? (ts_q - last_start_q) : '0;

        case (state_q)
            IDLE: begin
                if (enable && mon_ap_start) begin
                    if (done_hs) begin
                        done_evt     = 1'b1;
                        evt_start_ts = ts_q;
                        evt_ii       = start_ii;
                        last_start_d = ts_q;
                    end else begin
                        state_d    = RUN;
                        start_ts_d = ts_q;
                        ii_d       = start_ii;
                    end
                end
            end
            RUN: begin
                // Losing enable abandons the transaction without touching history.
                if (!enable) begin
                    state_d = IDLE;
                end else if (done_hs) begin
                    state_d      = IDLE;
                    done_evt     = 1'b1;
                    evt_start_ts = start_ts_q;
                    evt_lat      = ts_q - start_ts_q;
                    evt_ii       = ii_q;
                    last_start_d = start_ts_q;
                end
            end
            default: state_d = IDLE;
        endcase

        fifo_pop = !fifo_empty && rec_ready;
        seq_d    = done_evt ? seq_q + SEQ_W'(1) : seq_q;
        ovf_d    = ovf_q;
        if (done_evt && fifo_full && !fifo_pop && (ovf_q != '1)) begin
            ovf_d = ovf_q + SEQ_W'(1);
        end

        push_rec.seq      = PROF_SEQ_W'(seq_q);
        push_rec.start_ts = PROF_TS_W'(evt_start_ts);
        push_rec.lat      = PROF_TS_W'(evt_lat);
        push_rec.ii       = PROF_TS_W'(evt_ii);
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q      <= IDLE;
            ts_q         <= '0;
            start_ts_q   <= '0;
            ii_q         <= '0;
            last_start_q <= '0;
            ready_seen_q <= 1'b0;
            seq_q        <= '0;
            ovf_q        <= '0;
        end else begin
            state_q      <= state_d;
            ts_q         <= ts_d;
            start_ts_q   <= start_ts_d;
            ii_q         <= ii_d;
            last_start_q <= last_start_d;
            ready_seen_q <= ready_seen_d;
            seq_q        <= seq_d;
            ovf_q        <= ovf_d;
        end
    end

    prof_rec_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (ap_clk),
        .rst_n     (ap_rst_n),
        .push      (done_evt),
        .push_data (push_rec),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

    // Record fields read as zero whenever nothing is queued, including after reset.
    assign rec_valid    = !fifo_empty;
    assign rec_seq      = fifo_empty ? '0 : head.seq[SEQ_W-1:0];
    assign rec_start_ts = fifo_empty ? '0 : head.start_ts[TS_W-1:0];
    assign rec_lat      = fifo_empty ? '0 : head.lat[TS_W-1:0];
    assign rec_ii       = fifo_empty ? '0 : head.ii[TS_W-1:0];
    assign overflow_cnt = ovf_q;
    assign busy         = (state_q == RUN);

endmodule

// File: tb/tb_ap_txn_profiler.sv
// Directed and randomized bench for ap_txn_profiler against a transaction-level
// model: records are derived from the cycle numbers at which starts and dones occur.
module tb_ap_txn_profiler;

    localparam int DEPTH = 8;

    logic ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    logic        ap_rst_n, enable, st, rdy, dn, cont, rec_ready;
    logic        rec_valid, busy;
    logic [15:0] rec_seq, overflow_cnt;
    logic [31:0] rec_start_ts, rec_lat, rec_ii;

    logic        rst8_n, en8, st8, rdy8, dn8, cont8, ready8;
    logic        valid8, busy8;
    logic [15:0] seq8, ovf8;
    logic [7:0]  start8, lat8, ii8;

    ap_txn_profiler dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .enable(enable),
        .mon_ap_start(st), .mon_ap_ready(rdy), .mon_ap_done(dn), .mon_ap_continue(cont),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_seq(rec_seq),
        .rec_start_ts(rec_start_ts), .rec_lat(rec_lat), .rec_ii(rec_ii),
        .overflow_cnt(overflow_cnt), .busy(busy)
    );

    ap_txn_profiler #(.TS_W(8), .DEPTH(4), .SEQ_W(16)) dut8 (
        .ap_clk(ap_clk), .ap_rst_n(rst8_n), .enable(en8),
        .mon_ap_start(st8), .mon_ap_ready(rdy8), .mon_ap_done(dn8), .mon_ap_continue(cont8),
        .rec_valid(valid8), .rec_ready(ready8), .rec_seq(seq8),
        .rec_start_ts(start8), .rec_lat(lat8), .rec_ii(ii8),
        .overflow_cnt(ovf8), .busy(busy8)
    );

    typedef struct packed {
        logic [15:0] seq;
        logic [31:0] start_ts;
        logic [31:0] lat;
        logic [31:0] ii;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ts_m, last_start_m;
    logic [15:0] seq_m, ovf_m;
    logic        ready_seen_m, busy_m;
    int          ready_mode;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        exp_q.delete();
        ts_m = 0; seq_m = 0; ovf_m = 0;
        last_start_m = 0; ready_seen_m = 1'b0; busy_m = 1'b0;
    endtask

    // One clock cycle: compare outputs at the falling edge, then apply this cycle's
    // pop and done event to the model and advance to just after the next rising edge.
    task automatic cycle(input bit evt, input logic [31:0] s_ts, input logic [31:0] s_ii);
        bit pop, full;
        @(negedge ap_clk);
        check("rec_valid", rec_valid, exp_q.size() != 0);
        check("busy", busy, busy_m);
        check("overflow_cnt", overflow_cnt, ovf_m);
        if (exp_q.size() != 0) begin
            check("rec_seq", rec_seq, exp_q[0].seq);
            check("rec_start_ts", rec_start_ts, exp_q[0].start_ts);
            check("rec_lat", rec_lat, exp_q[0].lat);
            check("rec_ii", rec_ii, exp_q[0].ii);
        end
        pop  = (exp_q.size() != 0) && rec_ready;
        full = (exp_q.size() == DEPTH);
        if (pop) void'(exp_q.pop_front());
        if (evt) begin
            if (!full || pop) exp_q.push_back('{seq_m, s_ts, ts_m - s_ts, s_ii});
            else if (ovf_m != 16'hffff) ovf_m++;
            seq_m++;
        end
        @(posedge ap_clk);
        #1;
        ts_m++;
        rec_ready = (ready_mode == 0) ? 1'($urandom_range(0, 1)) : (ready_mode == 2);
    endtask

    // Idle for gap cycles, start, then complete wait_n cycles later after stall
    // extra cycles of done held without continue (wait_n == 0: zero-latency).
    task automatic run_txn(input int gap, input int wait_n, input int stall);
        logic [31:0] s, ii;
        st = 0; rdy = 0; dn = 0; cont = 1;
        repeat (gap) cycle(0, 0, 0);
        s  = ts_m;
        ii = ready_seen_m ? ts_m - last_start_m : 32'd0;
        st = 1; rdy = 1;
        if (wait_n == 0) begin
            dn = 1;
            cycle(1, s, ii);
            ready_seen_m = 1; last_start_m = s;
            st = 0; rdy = 0; dn = 0;
        end else begin
            cycle(0, 0, 0);
            ready_seen_m = 1; busy_m = 1;
            st = 0; rdy = 0;
            repeat (wait_n - 1) cycle(0, 0, 0);
            dn = 1; cont = 0;
            repeat (stall) cycle(0, 0, 0);
            cont = 1;
            cycle(1, s, ii);
            last_start_m = s; busy_m = 0; dn = 0;
        end
    endtask

    task automatic run_discard(input int wait_n);
        st = 1; rdy = 1; dn = 0; cont = 1;
        cycle(0, 0, 0);
        ready_seen_m = 1; busy_m = 1;
        st = 0; rdy = 0;
        repeat (wait_n - 1) cycle(0, 0, 0);
        enable = 0;
        cycle(0, 0, 0);
        enable = 1; busy_m = 0;
    endtask

    initial begin
        ap_rst_n = 0; enable = 0; st = 0; rdy = 0; dn = 0; cont = 1; rec_ready = 1;
        rst8_n = 0; en8 = 0; st8 = 0; rdy8 = 0; dn8 = 0; cont8 = 1; ready8 = 0;
        ready_mode = 2;
        repeat (2) @(posedge ap_clk);
        #1;
        ap_rst_n = 1; enable = 1;
        reset_model();
        #3;
        check("reset_valid", rec_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_ovf", overflow_cnt, 0);
        check("reset_seq", rec_seq, 0);
        check("reset_lat", rec_lat, 0);

        // Start at ts=10, done at ts=25.
        run_txn(10, 15, 0);
        #3;
        check("t1_seq", rec_seq, 0);
        check("t1_start", rec_start_ts, 10);
        check("t1_lat", rec_lat, 15);
        check("t1_ii", rec_ii, 0);

        // Start at ts=30, done at ts=34.
        run_txn(4, 4, 0);
        #3;
        check("t2_seq", rec_seq, 1);
        check("t2_lat", rec_lat, 4);
        check("t2_ii", rec_ii, 20);

        // Zero-latency transaction at ts=50.
        run_txn(15, 0, 0);
        #3;
        check("t4_start", rec_start_ts, 50);
        check("t4_lat", rec_lat, 0);

        // Start at ts=55, done held without continue at ts=60..62.
        run_txn(4, 5, 3);
        #3;
        check("t5_start", rec_start_ts, 55);
        check("t5_lat", rec_lat, 8);

        // Ten transactions into a stalled consumer: two records dropped.
        cycle(0, 0, 0);
        ready_mode = 1; rec_ready = 0;
        for (int i = 0; i < 10; i++) run_txn(1, 2, 0);
        #3;
        check("t3_ovf", overflow_cnt, 2);
        check("t3_head_seq", rec_seq, 4);
        ready_mode = 2; rec_ready = 1;
        repeat (DEPTH + 1) cycle(0, 0, 0);
        run_txn(0, 1, 0);
        #3;
        check("t3_next_seq", rec_seq, 14);

        // Randomized traffic with a random consumer and occasional enable drops.
        ready_mode = 0;
        for (int i = 0; i < 80; i++) begin
            int w;
            w = $urandom_range(0, 6);
            if ($urandom_range(0, 7) == 0 && w > 0) run_discard(w);
            else run_txn($urandom_range(0, 3), w, (w == 0) ? 0 : $urandom_range(0, 2));
        end

        // Reset while a transaction is in flight with a record queued.
        ready_mode = 1; rec_ready = 0;
        run_txn(0, 2, 0);
        st = 1; rdy = 1;
        cycle(0, 0, 0);
        st = 0; rdy = 0; busy_m = 1;
        cycle(0, 0, 0);
        ap_rst_n = 0;
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1;
        reset_model();
        #3;
        check("rst_busy", busy, 0);
        check("rst_valid", rec_valid, 0);
        check("rst_ovf", overflow_cnt, 0);
        ready_mode = 2; rec_ready = 1;
        run_txn(3, 2, 0);
        #3;
        check("rst_next_seq", rec_seq, 0);
        check("rst_next_ii", rec_ii, 0);
        cycle(0, 0, 0);

        // 8-bit timestamps: start at ts=250, done at ts=4 after the wrap.
        @(posedge ap_clk);
        #1;
        rst8_n = 1; en8 = 1;
        repeat (250) @(posedge ap_clk);
        #1;
        st8 = 1; rdy8 = 1;
        @(posedge ap_clk);
        #1;
        st8 = 0; rdy8 = 0;
        #3;
        check("w8_busy", busy8, 1);
        repeat (9) @(posedge ap_clk);
        #1;
        dn8 = 1;
        @(posedge ap_clk);
        #1;
        dn8 = 0;
        #3;
        check("w8_valid", valid8, 1);
        check("w8_seq", seq8, 0);
        check("w8_start", start8, 250);
        check("w8_lat", lat8, 10);
        check("w8_ii", ii8, 0);
        check("w8_busy_after", busy8, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
